// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1 : 8N1 UART receiver, LSB first, mid-bit sampling.
//   i_Clk       system clock (rising edge)
//   i_Rst       asynchronous active-high reset
//   i_RxD       serial line, idles high, asynchronous to i_Clk
//   o_Data      last correctly framed byte (held until the next good frame)
//   o_Valid     one-cycle pulse when o_Data is updated
//   o_Frame_Err one-cycle pulse when the stop bit is sampled low
//   o_Busy      high whenever the receiver is not idle
module uart_rx_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_RxD,
  output logic [7:0] o_Data,
  output logic       o_Valid,
  output logic       o_Frame_Err,
  output logic       o_Busy
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          r_sync1;
  logic          r_sync2;
  logic [2:0]    r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_frame_err;
  logic          r_busy;

  logic          w_rx_s;
  logic          w_half_done;
  logic          w_bit_done;
  logic [2:0]    w_state_nxt;
  logic [CW-1:0] w_clk_cnt_nxt;
  logic [2:0]    w_bit_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic [7:0]    w_data_nxt;
  logic          w_valid_nxt;
  logic          w_frame_err_nxt;

  assign w_rx_s      = r_sync2;
  assign w_half_done = (r_clk_cnt == CW'(HALF - 1));
  assign w_bit_done  = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));

  // State and datapath registers; synchroniser resets to the idle-high level.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sync1     <= i_RxD;
      r_sync2     <= r_sync1;
      r_state     <= w_state_nxt;
      r_clk_cnt   <= w_clk_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_clk_cnt_nxt   = r_clk_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_data_nxt      = r_data;
    w_valid_nxt     = 1'b0;
    w_frame_err_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_clk_cnt_nxt = '0;
        w_bit_idx_nxt = '0;
        if (!w_rx_s) begin
          w_state_nxt = S_START;
        end
      end

      // Re-check the line at mid start bit to reject glitches.
      S_START: begin
        if (w_half_done) begin
          w_clk_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CW'(1);
        end
      end

      // Shift right so the first received bit lands in bit 0.
      S_DATA: begin
        if (w_bit_done) begin
          w_clk_cnt_nxt = '0;
          w_shift_nxt   = {w_rx_s, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CW'(1);
        end
      end

      // Stop bit sampled at its centre; returning to IDLE here leaves half a
      // bit of slack before the next start edge.
      S_STOP: begin
        if (w_bit_done) begin
          w_clk_cnt_nxt = '0;
          if (w_rx_s) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = S_BREAK;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CW'(1);
        end
      end

      // Hold off until the line recovers so a break gives a single error.
      S_BREAK: begin
        w_clk_cnt_nxt = '0;
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_clk_cnt_nxt = '0;
        w_bit_idx_nxt = '0;
      end
    endcase
  end

  assign o_Data      = r_data;
  assign o_Valid     = r_valid;
  assign o_Frame_Err = r_frame_err;
  assign o_Busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1 : randomized self-checking bench for uart_rx_8n1.
// A behavioural serial sender drives i_RxD with bit edges placed at
// round(k * period); received bytes are checked against the bytes sent.
module tb_uart_rx_8n1;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;

  // Observations collected by the monitor.
  logic [7:0]  obs_q[$];
  int unsigned obs_cyc[$];
  int unsigned fe_cnt   = 0;
  int unsigned both_cnt = 0;
  int unsigned busy_cnt = 0;

  uart_rx_8n1 #(.CLKS_PER_BIT(16)) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_RxD      (rxd),
    .o_Data     (data),
    .o_Valid    (valid),
    .o_Frame_Err(frame_err),
    .o_Busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    if (valid) begin
      obs_q.push_back(data);
      obs_cyc.push_back(cyc);
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (valid && frame_err) both_cnt = both_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serial sender: period given in hundredths of a clock cycle.
  task automatic send_frame(input logic [7:0] b, input int unsigned p100, input logic stop_v);
    logic [9:0] bits;
    int unsigned t_prev;
    int unsigned t_next;
    bits   = {stop_v, b, 1'b0};
    t_prev = 0;
    for (int k = 0; k < 10; k++) begin
      rxd    = bits[k];
      t_next = ((k + 1) * p100 + 50) / 100;
      repeat (t_next - t_prev) step();
      t_prev = t_next;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) step();
    if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    rst = 1'b0;
    repeat (5) step();
  endtask

  // Check one received byte from index base, plus no new frame errors.
  task automatic test_nominal();
    int unsigned base;
    int unsigned fe0;
    int unsigned st;
    int unsigned n;
    logic [7:0]  got;
    int unsigned lat;
    base = obs_q.size();
    fe0  = fe_cnt;
    st   = cyc;
    send_frame(8'h61, 1600, 1'b1);
    repeat (30) step();
    n   = obs_q.size() - base;
    got = (n >= 1) ? obs_q[base] : 8'hxx;
    lat = (n >= 1) ? obs_cyc[base] - st : 0;
    if (n != 1) begin errors++; $display("FAIL nominal_count: got %0d want 1", n); end
    checks++;
    if (got !== 8'h61) begin errors++; $display("FAIL nominal_data: got %h want 61", got); end
    checks++;
    if (lat != 155) begin errors++; $display("FAIL nominal_latency: got %0d want 155", lat); end
    checks++;
    if (fe_cnt != fe0) begin errors++; $display("FAIL nominal_ferr: got %0d want 0", fe_cnt - fe0); end
    checks++;
    if (data !== 8'h61) begin errors++; $display("FAIL nominal_hold: got %h want 61", data); end
    checks++;
  endtask

  task automatic test_glitch();
    int unsigned base;
    int unsigned fe0;
    int unsigned b0;
    logic [7:0]  got;
    base = obs_q.size();
    fe0  = fe_cnt;
    b0   = busy_cnt;
    rxd  = 1'b0;
    repeat (4) step();
    rxd  = 1'b1;
    repeat (40) step();
    if (busy_cnt == b0) begin errors++; $display("FAIL glitch_busy_pulse: got 0 busy cycles want >0"); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
    checks++;
    if (obs_q.size() != base || fe_cnt != fe0) begin
      errors++; $display("FAIL glitch_pulses: got valid=%0d ferr=%0d want 0 0", obs_q.size() - base, fe_cnt - fe0);
    end
    checks++;
    send_frame(8'hA5, 1600, 1'b1);
    repeat (30) step();
    got = (obs_q.size() == base + 1) ? obs_q[base] : 8'hxx;
    if (got !== 8'hA5) begin errors++; $display("FAIL glitch_next_frame: got %h want a5", got); end
    checks++;
  endtask

  task automatic test_frame_err();
    int unsigned base;
    int unsigned fe0;
    logic [7:0]  got;
    base = obs_q.size();
    fe0  = fe_cnt;
    send_frame(8'h3C, 1600, 1'b0);
    repeat (640) step();
    if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", fe_cnt - fe0); end
    checks++;
    if (obs_q.size() != base) begin errors++; $display("FAIL ferr_valid: got %0d want 0", obs_q.size() - base); end
    checks++;
    if (data !== 8'hA5) begin errors++; $display("FAIL ferr_data_hold: got %h want a5", data); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_break: got %b want 1", busy); end
    checks++;
    rxd = 1'b1;
    repeat (10) step();
    if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b want 0", busy); end
    checks++;
    send_frame(8'h7E, 1600, 1'b1);
    repeat (30) step();
    got = (obs_q.size() == base + 1) ? obs_q[base] : 8'hxx;
    if (got !== 8'h7E) begin errors++; $display("FAIL ferr_next_frame: got %h want 7e", got); end
    checks++;
  endtask

  // Sends a list of bytes with no gap and checks them all in order.
  task automatic run_burst(input string name, input logic [7:0] bytes[$], input int unsigned p100);
    int unsigned base;
    int unsigned fe0;
    logic [7:0]  got;
    base = obs_q.size();
    fe0  = fe_cnt;
    foreach (bytes[i]) send_frame(bytes[i], p100, 1'b1);
    repeat (40) step();
    if (obs_q.size() - base != bytes.size()) begin
      errors++; $display("FAIL %s_count: got %0d want %0d", name, obs_q.size() - base, bytes.size());
    end
    checks++;
    foreach (bytes[i]) begin
      got = (base + i < obs_q.size()) ? obs_q[base + i] : 8'hxx;
      if (got !== bytes[i]) begin errors++; $display("FAIL %s_byte%0d: got %h want %h", name, i, got, bytes[i]); end
      checks++;
    end
    if (fe_cnt != fe0) begin errors++; $display("FAIL %s_ferr: got %0d want 0", name, fe_cnt - fe0); end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[$];
    bytes = '{8'h55, 8'hAA, 8'h00, 8'hFF};
    run_burst("b2b", bytes, 1600);
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0]  bits;
    int unsigned base;
    int unsigned fe0;
    logic [7:0]  got;
    bits = {1'b1, 8'h12, 1'b0};
    base = obs_q.size();
    fe0  = fe_cnt;
    for (int k = 0; k < 5; k++) begin
      rxd = bits[k];
      repeat (16) step();
    end
    rxd = bits[5];
    repeat (8) step();
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    checks++;
    rst = 1'b1;
    #1;
    if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: got data=%h v=%b fe=%b busy=%b want 00 0 0 0", data, valid, frame_err, busy);
    end
    checks++;
    repeat (3) step();
    rst = 1'b0;
    rxd = 1'b1;
    repeat (200) step();
    if (obs_q.size() != base || fe_cnt != fe0) begin
      errors++; $display("FAIL midrst_pulses: got valid=%0d ferr=%0d want 0 0", obs_q.size() - base, fe_cnt - fe0);
    end
    checks++;
    send_frame(8'h34, 1600, 1'b1);
    repeat (30) step();
    got = (obs_q.size() == base + 1) ? obs_q[base] : 8'hxx;
    if (got !== 8'h34) begin errors++; $display("FAIL midrst_next_frame: got %h want 34", got); end
    checks++;
  endtask

  // Sender running 3% slow and 3% fast against the receiver.
  task automatic test_baud_skew();
    logic [7:0] bytes[$];
    for (int i = 0; i < 64; i++) bytes.push_back(8'($urandom));
    run_burst("skew_slow", bytes, 1648);
    bytes.delete();
    for (int i = 0; i < 64; i++) bytes.push_back(8'($urandom));
    run_burst("skew_fast", bytes, 1552);
  endtask

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    test_reset();
    test_nominal();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_baud_skew();
    if (both_cnt != 0) begin errors++; $display("FAIL exclusive_pulses: got %0d overlaps want 0", both_cnt); end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
